// File: rtl/aes_byte_loader_if.sv
// Byte-stream input and 128-bit result output bundle for aes_byte_loader.
// slave: loader side; master: producer/consumer side.
interface aes_byte_loader_if;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_ready;
    logic         s_key_upd;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport slave (
        input  s_data, s_valid, s_key_upd, m_ready,
        output s_ready, m_data, m_valid
    );

    modport master (
        output s_data, s_valid, s_key_upd, m_ready,
        input  s_ready, m_data, m_valid
    );
endinterface

// File: rtl/aes_byte_loader.sv
// Byte-serial front end for a combinational AES-128 core.
// Ports: clk, rst_n; bus (s_* byte stream in, m_* 128-bit result out);
// core_key/core_plaintext to core, core_cyphertext from core; busy, key_loaded.
module aes_byte_loader #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_byte_loader_if.slave      bus,
    output logic [127:0]          core_key,
    output logic [127:0]          core_plaintext,
    input  logic [127:0]          core_cyphertext,
    output logic                  busy,
    output logic                  key_loaded
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_KEY = 3'd1;
    localparam logic [2:0] LOAD_PT  = 3'd2;
    localparam logic [2:0] SETTLE   = 3'd3;
    localparam logic [2:0] OUT      = 3'd4;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [2:0]   r_state;
    logic [3:0]   r_byte_cnt;
    logic [3:0]   r_settle_cnt;
    logic [127:0] r_key;
    logic [127:0] r_pt;
    logic [127:0] r_m_data;
    logic         r_m_valid;
    logic         r_key_loaded;
    // Keeps s_ready low until the first edge after reset release.
    logic         r_rdy_en;

    logic         w_in_load;
    logic         w_xfer;

    assign w_in_load = (r_state == IDLE) || (r_state == LOAD_KEY) ||
                       (r_state == LOAD_PT);
    assign w_xfer    = bus.s_valid && bus.s_ready;

    assign bus.s_ready    = r_rdy_en && w_in_load;
    assign bus.m_data     = r_m_data;
    assign bus.m_valid    = r_m_valid;
    assign core_key       = r_key;
    assign core_plaintext = r_pt;
    assign busy           = (r_state != IDLE);
    assign key_loaded     = r_key_loaded;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_byte_cnt   <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_key        <= '0;
            r_pt         <= '0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_key_loaded <= 1'b0;
            r_rdy_en     <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            unique case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_byte_cnt <= 4'd1;
                        if (bus.s_key_upd) begin
                            r_key   <= {r_key[119:0], bus.s_data};
                            r_state <= LOAD_KEY;
                        end else begin
                            r_pt    <= {r_pt[119:0], bus.s_data};
                            r_state <= LOAD_PT;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (w_xfer) begin
                        r_key <= {r_key[119:0], bus.s_data};
                        if (r_byte_cnt == 4'd15) begin
                            r_key_loaded <= 1'b1;
                            r_byte_cnt   <= 4'd0;
                            r_state      <= LOAD_PT;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                        end
                    end
                end
                LOAD_PT: begin
                    if (w_xfer) begin
                        r_pt <= {r_pt[119:0], bus.s_data};
                        if (r_byte_cnt == 4'd15) begin
                            r_byte_cnt   <= 4'd0;
                            r_settle_cnt <= 4'd0;
                            r_state      <= SETTLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    // Core inputs held stable; capture once the path has settled.
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_m_data  <= core_cyphertext;
                        r_m_valid <= 1'b1;
                        r_state   <= OUT;
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader with an XOR stub core.
// Two instances: SETTLE_CYCLES=4 (unit 0) and SETTLE_CYCLES=1 (unit 1).
module tb_aes_byte_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_byte_loader_if bus0();
    aes_byte_loader_if bus1();

    logic [127:0] ck0, cp0, cc0, ck1, cp1, cc1;
    logic         busy0, kl0, busy1, kl1;

    assign cc0 = cp0 ^ ck0;
    assign cc1 = cp1 ^ ck1;

    aes_byte_loader #(.SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
        .core_key(ck0), .core_plaintext(cp0), .core_cyphertext(cc0),
        .busy(busy0), .key_loaded(kl0)
    );

    aes_byte_loader #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
        .core_key(ck1), .core_plaintext(cp1), .core_cyphertext(cc1),
        .busy(busy1), .key_loaded(kl1)
    );

    typedef struct {
        logic [127:0] d;
        int           e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t x0, x1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc[2];
    logic pv0 = 1'b0;
    logic pv1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [127:0] a, logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, a, e);
        end
    endtask

    // Monitor: on every rising m_valid pop one expectation and compare.
    always @(negedge clk) begin
        if (rst_n && bus0.m_valid && !pv0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected0 act=%h exp=none", bus0.m_data);
            end else begin
                x0 = q0.pop_front();
                chk("m_data0", bus0.m_data, x0.d);
                chk("latency0", 128'(cyc), 128'(x0.e));
            end
        end
        if (rst_n && bus1.m_valid && !pv1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected1 act=%h exp=none", bus1.m_data);
            end else begin
                x1 = q1.pop_front();
                chk("m_data1", bus1.m_data, x1.d);
                chk("latency1", 128'(cyc), 128'(x1.e));
            end
        end
        pv0 <= bus0.m_valid;
        pv1 <= bus1.m_valid;
    end

    function automatic logic rdy(int u);
        return (u == 0) ? bus0.s_ready : bus1.s_ready;
    endfunction

    task automatic drive(int u, logic v, logic [7:0] d, logic k);
        if (u == 0) begin
            bus0.s_valid = v; bus0.s_data = d; bus0.s_key_upd = k;
        end else begin
            bus1.s_valid = v; bus1.s_data = d; bus1.s_key_upd = k;
        end
    endtask

    task automatic send_byte(int u, logic [7:0] d, logic k);
        int n = 0;
        @(negedge clk);
        drive(u, 1'b1, d, k);
        while (!rdy(u) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL s_ready_timeout act=0 exp=1");
        end
        @(posedge clk);
        #1;
        last_acc[u] = cyc;
        drive(u, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_field(int u, logic [127:0] v, logic k0,
                              int bubble, int kupd_at);
        logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = v[127 - 8*i -: 8];
            send_byte(u, b, (i == 0) ? k0 : (i == kupd_at));
            if (bubble != 0 && i < 15) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic frame(int u, logic kf, logic [127:0] key,
                         logic [127:0] pt, int bubble, int kupd_at,
                         logic [127:0] exp);
        exp_t t;
        if (kf) send_field(u, key, 1'b1, 0, -1);
        send_field(u, pt, 1'b0, bubble, kupd_at);
        t.d = exp;
        t.e = last_acc[u] + ((u == 0) ? 4 : 1);
        if (u == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    task automatic wait_idle(int u);
        int n = 0;
        @(negedge clk);
        while (((u == 0) ? busy0 : busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL idle_timeout act=busy exp=idle");
        end
    endtask

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] EXP1 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] PT3  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] EXP3 = 128'h012247648daecbe8f6d5b0937a593c1f;

    initial begin
        int n;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        bus0.m_ready = 1'b1;
        bus1.m_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_key", ck0, '0);
        chk("rst_pt", cp0, '0);
        chk("rst_mdata", bus0.m_data, '0);
        chk("rst_mvalid", 128'(bus0.m_valid), 0);
        chk("rst_busy", 128'(busy0), 0);
        chk("rst_keyld", 128'(kl0), 0);
        chk("rst_sready", 128'(bus0.s_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_sready_lo", 128'(bus0.s_ready), 0);
        @(posedge clk);
        #1;
        chk("rel_sready_hi", 128'(bus0.s_ready), 1);

        // 1: key + plaintext, no stalls
        frame(0, 1'b1, KEY1, PT1, 0, -1, EXP1);
        wait_idle(0);
        chk("t1_keyld", 128'(kl0), 1);
        chk("t1_key", ck0, KEY1);

        // 2: plaintext only, key retained
        frame(0, 1'b0, '0, {128{1'b1}}, 0, -1,
              128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
        wait_idle(0);
        chk("t2_key", ck0, KEY1);

        // 3: output backpressure
        bus0.m_ready = 1'b0;
        frame(0, 1'b0, '0, PT3, 0, -1, EXP3);
        n = 0;
        @(negedge clk);
        while (!bus0.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t3_mvalid", 128'(bus0.m_valid), 1);
            chk("t3_mdata", bus0.m_data, EXP3);
            chk("t3_sready", 128'(bus0.s_ready), 0);
            if (i < 4) @(negedge clk);
        end
        bus0.m_ready = 1'b1;
        @(negedge clk);
        chk("t3_busy", 128'(busy0), 0);
        chk("t3_sready_up", 128'(bus0.s_ready), 1);
        chk("t3_mvalid_lo", 128'(bus0.m_valid), 0);

        // 4: bubbles in the plaintext field
        frame(0, 1'b0, '0, PT1, 1, -1, EXP1);
        wait_idle(0);

        // 5: reset mid key field
        for (int i = 0; i < 7; i++) send_byte(0, 8'(i), (i == 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_key", ck0, '0);
        chk("t5_pt", cp0, '0);
        chk("t5_mdata", bus0.m_data, '0);
        chk("t5_busy", 128'(busy0), 0);
        chk("t5_keyld", 128'(kl0), 0);
        chk("t5_sready", 128'(bus0.s_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 1'b1, '0, '0, 0, -1, '0);
        wait_idle(0);
        chk("t5_keyld_after", 128'(kl0), 1);

        // 6: SETTLE_CYCLES=1, s_key_upd on byte 3 ignored
        frame(1, 1'b0, '0, 128'h101112131415161718191a1b1c1d1e1f, 0, 2,
              128'h101112131415161718191a1b1c1d1e1f);
        wait_idle(1);
        chk("t6_keyld", 128'(kl1), 0);
        chk("t6_key", ck1, '0);

        repeat (3) @(negedge clk);
        chk("q0_empty", 128'(q0.size()), 0);
        chk("q1_empty", 128'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
